// File: rtl/pipelined_adder_pkg.sv
// Shared op encodings, default width and flag bundle for the pipelined add/subtract unit.
package pipelined_adder_pkg;

   localparam logic ALU_OP_ADD = 1'b0;
   localparam logic ALU_OP_SUB = 1'b1;
   localparam int   DATA_WIDTH = 32;

   typedef struct packed {
      logic c_out;
      logic ovf;
      logic zero;
   } alu_flags_t;

   // Subtraction is run as a + ~b + ~borrow so every stage stays a plain adder.
   function automatic logic prep_carry(input logic op, input logic carry);
      return (op == ALU_OP_SUB) ? ~carry : carry;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder; slave is the adder, master is the producer/consumer side.
interface pipelined_adder_if
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, zero
   );

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, zero
   );
endinterface

// File: rtl/pipelined_adder_stage.sv
// One CHUNK-bit slice of the pipelined adder with its valid/ready register; 1 cycle per stage.
// Loads whenever empty or the next stage drains, so bubbles collapse under a downstream stall.
module adder_stage #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 16,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prev_vld,
   input  logic             next_rdy,
   output logic             stage_rdy,
   output logic             vld,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] bb,
   input  logic [WIDTH-1:0] part,
   input  logic             carry,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] bb_q,
   output logic [WIDTH-1:0] part_q,
   output logic             carry_q
);
   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] part_nxt;

   assign stage_rdy = !vld || next_rdy;
   assign slice_sum = {1'b0, a[IDX*CHUNK +: CHUNK]} + {1'b0, bb[IDX*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry};

   always_comb begin
      part_nxt = part;
      part_nxt[IDX*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld     <= 1'b0;
         a_q     <= '0;
         bb_q    <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
      end else if (stage_rdy) begin
         vld <= prev_vld;
         if (prev_vld) begin
            a_q     <= a;
            bb_q    <= bb;
            part_q  <= part_nxt;
            carry_q <= slice_sum[CHUNK];
         end
      end
   end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with carry/overflow/zero flags; NSTAGE = WIDTH/CHUNK cycles latency, 1 beat/cycle.
// Per-stage valid/ready: a stalled consumer holds every full stage and drops in_ready.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int CHUNK = 16
) (
   input logic              clk,
   input logic              rst,
   pipelined_adder_if.slave bus
);
   localparam int NSTAGE = WIDTH / CHUNK;

   if (((WIDTH % CHUNK) != 0) || (NSTAGE < 1)) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic             vld     [NSTAGE];
   logic             rdy     [NSTAGE+1];
   logic [WIDTH-1:0] a_q     [NSTAGE];
   logic [WIDTH-1:0] bb_q    [NSTAGE];
   logic [WIDTH-1:0] part_q  [NSTAGE];
   logic             carry_q [NSTAGE];
   logic [WIDTH-1:0] bb_in;
   logic             cin_eff;
   alu_flags_t       flags;
   logic             unused_pass;

   assign bb_in        = (bus.sub == ALU_OP_SUB) ? ~bus.b : bus.b;
   assign cin_eff      = prep_carry(bus.sub, bus.c_in);
   assign rdy[NSTAGE]  = bus.out_ready;
   assign bus.in_ready = rdy[0];

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      if (k == 0) begin : g_first
         adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .prev_vld (bus.in_valid),
            .next_rdy (rdy[k+1]),
            .stage_rdy(rdy[k]),
            .vld      (vld[k]),
            .a        (bus.a),
            .bb       (bb_in),
            .part     ('0),
            .carry    (cin_eff),
            .a_q      (a_q[k]),
            .bb_q     (bb_q[k]),
            .part_q   (part_q[k]),
            .carry_q  (carry_q[k])
         );
      end else begin : g_next
         adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .prev_vld (vld[k-1]),
            .next_rdy (rdy[k+1]),
            .stage_rdy(rdy[k]),
            .vld      (vld[k]),
            .a        (a_q[k-1]),
            .bb       (bb_q[k-1]),
            .part     (part_q[k-1]),
            .carry    (carry_q[k-1]),
            .a_q      (a_q[k]),
            .bb_q     (bb_q[k]),
            .part_q   (part_q[k]),
            .carry_q  (carry_q[k])
         );
      end
   end

   // Overflow compares sign bits of the operands as actually added (b already inverted for sub).
   assign flags = '{
      c_out: carry_q[NSTAGE-1],
      ovf:   (a_q[NSTAGE-1][WIDTH-1] == bb_q[NSTAGE-1][WIDTH-1]) &&
             (part_q[NSTAGE-1][WIDTH-1] != a_q[NSTAGE-1][WIDTH-1]),
      zero:  ~|part_q[NSTAGE-1]
   };

   assign bus.out_valid = vld[NSTAGE-1];
   assign bus.sum       = part_q[NSTAGE-1];
   assign bus.c_out     = flags.c_out;
   assign bus.ovf       = flags.ovf;
   assign bus.zero      = flags.zero;

   assign unused_pass = ^{a_q[NSTAGE-1][WIDTH-2:0], bb_q[NSTAGE-1][WIDTH-2:0]};
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on a 32/16 instance plus random sweeps over four geometries.
module tb_pipelined_adder;
   import pipelined_adder_pkg::*;

   typedef struct packed {
      logic [63:0] sum;
      logic        c;
      logic        o;
      logic        z;
   } res_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  rst_sw = 1'b1;
   int    checks = 0;
   int    errors = 0;
   int    n_pop = 0;
   string phase = "init";
   res_t  sb0[$];
   bit    sw_done [4];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic res_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
      res_t r;
      r.sum = s; r.c = c; r.o = o; r.z = z;
      return r;
   endfunction

   // Reference: unsigned carry/borrow and signed range test on wide integers.
   function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input logic sub);
      res_t r;
      logic [63:0] mask;
      logic [67:0] ua, ub, uc, ur;
      logic signed [67:0] sa, sb, sc, sr, smax, smin;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      ua = {4'b0, a & mask};
      ub = {4'b0, b & mask};
      uc = {67'b0, cin};
      if (sub) begin
         ur  = ua - ub - uc;
         r.c = (ua >= ub + uc);
      end else begin
         ur  = ua + ub + uc;
         r.c = ur[w];
      end
      r.sum = ur[63:0] & mask;
      r.z   = (r.sum == 64'd0);
      sa = $signed(ua);
      sb = $signed(ub);
      sc = $signed(uc);
      if (ua[w-1]) sa = sa - (68'sd1 <<< w);
      if (ub[w-1]) sb = sb - (68'sd1 <<< w);
      sr   = sub ? (sa - sb - sc) : (sa + sb + sc);
      smax = (68'sd1 <<< (w - 1)) - 68'sd1;
      smin = -(68'sd1 <<< (w - 1));
      r.o  = (sr > smax) || (sr < smin);
      return r;
   endfunction

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 64'h0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_8000_0000;
         3:       return 64'h7FFF_FFFF_7FFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   pipelined_adder_if #(.WIDTH(32)) m ();
   pipelined_adder #(.WIDTH(32), .CHUNK(16)) u_dut (.clk(clk), .rst(rst), .bus(m));

   always @(negedge clk) begin
      if (!rst && m.out_valid && m.out_ready) begin
         if (sb0.size() == 0) begin
            check({phase, "_spurious"}, 64'(m.out_valid), 64'd0);
         end else begin
            res_t e;
            e = sb0.pop_front();
            n_pop++;
            check({phase, "_sum"},   64'(m.sum),   e.sum);
            check({phase, "_c_out"}, 64'(m.c_out), 64'(e.c));
            check({phase, "_ovf"},   64'(m.ovf),   64'(e.o));
            check({phase, "_zero"},  64'(m.zero),  64'(e.z));
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input res_t exp);
      int n;
      m.in_valid = 1'b1; m.a = a; m.b = b; m.c_in = cin; m.sub = sub;
      n = 0;
      forever begin
         @(negedge clk);
         if (m.in_ready) begin
            sb0.push_back(exp);
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 50) begin
            check({phase, "_accept_timeout"}, 64'(m.in_ready), 64'd1);
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic latency(input logic [31:0] a, input logic [31:0] b, input res_t exp,
                          input string tag);
      int n;
      send(a, b, 1'b0, ALU_OP_ADD, exp);
      m.in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m.out_valid && n < 20);
      check(tag, 64'(n), 64'd2);
   endtask

   task automatic wait_drain();
      int n;
      m.in_valid = 1'b0;
      m.out_ready = 1'b1;
      n = 0;
      while (sb0.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check({phase, "_drained"}, 64'(sb0.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n0;
      logic [3:0] dv;
      m.in_valid = 1'b0; m.a = '0; m.b = '0; m.c_in = 1'b0; m.sub = 1'b0; m.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rst_sw = 1'b0;

      phase = "reset";
      @(negedge clk);
      check("reset_out_valid", 64'(m.out_valid), 64'd0);
      check("reset_sum",       64'(m.sum),       64'd0);
      check("reset_c_out",     64'(m.c_out),     64'd0);
      check("reset_ovf",       64'(m.ovf),       64'd0);
      check("reset_zero",      64'(m.zero),      64'd1);
      check("reset_in_ready",  64'(m.in_ready),  64'd1);
      @(posedge clk); #1;

      phase = "t1";
      latency(32'h0000FFFF, 32'h00000001, mk(64'h00010000, 1'b0, 1'b0, 1'b0), "t1_latency");
      wait_drain();

      phase = "t2";
      send(32'h7FFFFFFF, 32'h1, 1'b0, ALU_OP_ADD, mk(64'h80000000, 1'b0, 1'b1, 1'b0));
      send(32'h80000000, 32'h1, 1'b0, ALU_OP_SUB, mk(64'h7FFFFFFF, 1'b1, 1'b1, 1'b0));
      wait_drain();

      phase = "t3";
      send(32'hFFFFFFFF, 32'h1, 1'b0, ALU_OP_ADD, mk(64'h0, 1'b1, 1'b0, 1'b1));
      send(32'h5,        32'h5, 1'b0, ALU_OP_SUB, mk(64'h0, 1'b1, 1'b0, 1'b1));
      send(32'h5,        32'h5, 1'b1, ALU_OP_SUB, mk(64'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
      send(32'hFFFFFFFE, 32'h0, 1'b1, ALU_OP_ADD, mk(64'hFFFFFFFF, 1'b0, 1'b0, 1'b0));
      wait_drain();

      phase = "t4";
      n0 = n_pop;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(32'(i), 32'(i), 1'b0, ALU_OP_ADD, mk(64'(2 * i), 1'b0, 1'b0, i == 0));
            m.in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 m.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("t4_stall_in_ready",  64'(m.in_ready),  64'd0);
               check("t4_stall_out_valid", 64'(m.out_valid), 64'd1);
               @(posedge clk);
            end
            #1 m.out_ready = 1'b1;
         end
      join
      wait_drain();
      check("t4_count", 64'(n_pop - n0), 64'd6);

      phase = "t5";
      send(32'd1, 32'd2, 1'b0, ALU_OP_ADD, mk(64'd3, 1'b0, 1'b0, 1'b0));
      send(32'd3, 32'd4, 1'b0, ALU_OP_ADD, mk(64'd7, 1'b0, 1'b0, 1'b0));
      m.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t5_async_out_valid", 64'(m.out_valid), 64'd0);
      sb0.delete();
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t5_idle_out_valid", 64'(m.out_valid), 64'd0);
      end
      @(posedge clk); #1;
      latency(32'h10, 32'h20, mk(64'h30, 1'b0, 1'b0, 1'b0), "t5_latency");
      wait_drain();

      phase = "done";
      for (int i = 0; i < 20000; i++) begin
         if (sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3]) break;
         @(posedge clk);
      end
      dv = {sw_done[3], sw_done[2], sw_done[1], sw_done[0]};
      check("sweep_done", 64'(dv), 64'hF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int W   = (g == 3) ? 64 : 32;
      localparam int C   = (g == 1) ? 32 : ((g == 2) ? 8 : 16);
      localparam int NST = W / C;

      pipelined_adder_if #(.WIDTH(W)) sw ();
      pipelined_adder #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst(rst_sw), .bus(sw));

      res_t  q[$];
      string tag = $sformatf("w%0dc%0d", W, C);

      always @(negedge clk) begin
         if (!rst_sw && sw.out_valid && sw.out_ready) begin
            if (q.size() == 0) begin
               check({tag, "_spurious"}, 64'(sw.out_valid), 64'd0);
            end else begin
               res_t e;
               e = q.pop_front();
               check({tag, "_sum"},   64'(sw.sum),   e.sum);
               check({tag, "_c_out"}, 64'(sw.c_out), 64'(e.c));
               check({tag, "_ovf"},   64'(sw.ovf),   64'(e.o));
               check({tag, "_zero"},  64'(sw.zero),  64'(e.z));
            end
         end
      end

      initial begin
         logic [63:0] ra, rb;
         logic rc, rs, took;
         int n;
         sw.in_valid = 1'b0; sw.a = '0; sw.b = '0; sw.c_in = 1'b0; sw.sub = 1'b0;
         sw.out_ready = 1'b1;
         @(negedge rst_sw);
         @(posedge clk); #1;

         ra = rnd_op();
         rb = rnd_op();
         sw.in_valid = 1'b1; sw.a = W'(ra); sw.b = W'(rb); sw.c_in = 1'b0; sw.sub = 1'b0;
         @(negedge clk);
         check({tag, "_lat_accept"}, 64'(sw.in_ready), 64'd1);
         if (sw.in_ready) q.push_back(ref_model(W, ra, rb, 1'b0, 1'b0));
         @(posedge clk); #1 sw.in_valid = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!sw.out_valid && n < 20);
         check({tag, "_latency"}, 64'(n), 64'(NST));

         took = 1'b0;
         for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (!sw.in_valid || took) begin
               ra = rnd_op();
               rb = rnd_op();
               rc = 1'($urandom_range(0, 1));
               rs = 1'($urandom_range(0, 1));
               sw.in_valid = ($urandom_range(0, 3) != 0);
               sw.a = W'(ra); sw.b = W'(rb); sw.c_in = rc; sw.sub = rs;
            end
            sw.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = sw.in_valid && sw.in_ready;
            if (took) q.push_back(ref_model(W, ra, rb, rc, rs));
         end
         @(posedge clk); #1;
         sw.in_valid = 1'b0;
         sw.out_ready = 1'b1;
         n = 0;
         while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
         end
         check({tag, "_drained"}, 64'(q.size()), 64'd0);
         sw_done[g] = 1'b1;
      end
   end
endmodule
